// File: rtl/mod_12_counter.sv
// Free-running modulo-MODULUS up-counter with a registered terminal-count flag.
// Out-of-range states collapse to zero on the next edge.
module mod_12_counter #(
    parameter int MODULUS = 12,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic [WIDTH-1:0] count_nxt_s;
    logic             tc_nxt_s;

    // Next-state: wrap on the last legal value, and treat anything above it as an upset.
    always_comb begin
        count_nxt_s = '0;
        tc_nxt_s    = 1'b0;
        if (count_r >= LAST_VAL) begin
            count_nxt_s = '0;
        end else begin
            count_nxt_s = count_r + ONE_VAL;
        end
        tc_nxt_s = (count_nxt_s == LAST_VAL);
    end

    // State register; tc is computed from the next count so it lines up with count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
            tc_r    <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            tc_r    <= tc_nxt_s;
        end
    end

    assign count = count_r;
    assign tc    = tc_r;

endmodule

// File: tb/tb_mod_12_counter.sv
// Directed testbench for mod_12_counter: reset hold, counting, wrap,
// asynchronous reset, reset at terminal count and illegal-state recovery.
module tb_mod_12_counter;

    logic       clk;
    logic       reset;
    logic [3:0] count;
    logic       tc;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_count = 0;

    mod_12_counter #(.MODULUS(12), .WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .count (count),
        .tc    (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the next falling edge; the rising edge before it advanced the expected value.
    task automatic step();
        @(negedge clk);
        if (reset) exp_count = (exp_count == 11) ? 0 : exp_count + 1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        exp_count = 0;
        #1;
        total_cnt++;
        if (count !== 4'd0 || tc !== 1'b0)
            $display("FAIL reset_initial: count=%0d tc=%0b required count=0 tc=0", count, tc);
        else pass_cnt++;
        // Rising edge at 5 ns while in reset; sample at the 10 ns falling edge.
        step();
        total_cnt++;
        if (count !== 4'd0 || tc !== 1'b0)
            $display("FAIL reset_hold: count=%0d tc=%0b required count=0 tc=0", count, tc);
        else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic test_count_up();
        for (int i = 1; i <= 11; i++) begin
            step();
            total_cnt++;
            if (count !== 4'(i) || tc !== (i == 11))
                $display("FAIL count_up_%0d: count=%0d tc=%0b required count=%0d tc=%0b",
                         i, count, tc, i, (i == 11));
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            step();
            total_cnt++;
            if (count !== 4'(exp_count) || tc !== (exp_count == 11) || count > 4'd11)
                $display("FAIL wrap_%0d: count=%0d tc=%0b required count=%0d tc=%0b",
                         i, count, tc, exp_count, (exp_count == 11));
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset_mid();
        for (int i = 0; i < 12 && exp_count != 7; i++) step();
        total_cnt++;
        if (count !== 4'd7)
            $display("FAIL async_pre: count=%0d required 7", count);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (count !== 4'd0 || tc !== 1'b0)
            $display("FAIL async_clear: count=%0d tc=%0b required count=0 tc=0", count, tc);
        else pass_cnt++;
        exp_count = 0;
        step();
        total_cnt++;
        if (count !== 4'd0)
            $display("FAIL async_hold: count=%0d required 0", count);
        else pass_cnt++;
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            total_cnt++;
            if (count !== 4'(i) || tc !== 1'b0)
                $display("FAIL async_resume_%0d: count=%0d tc=%0b required count=%0d tc=0",
                         i, count, tc, i);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_at_tc();
        for (int i = 0; i < 12 && exp_count != 11; i++) step();
        total_cnt++;
        if (count !== 4'd11 || tc !== 1'b1)
            $display("FAIL tc_pre: count=%0d tc=%0b required count=11 tc=1", count, tc);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (count !== 4'd0 || tc !== 1'b0)
            $display("FAIL tc_clear: count=%0d tc=%0b required count=0 tc=0", count, tc);
        else pass_cnt++;
        exp_count = 0;
        step();
        reset = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            step();
            total_cnt++;
            if (count !== 4'(i) || tc !== (i == 11))
                $display("FAIL tc_after_%0d: count=%0d tc=%0b required count=%0d tc=%0b",
                         i, count, tc, i, (i == 11));
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal_state();
        step();
        force dut.count_r = 4'd13;
        #1;
        release dut.count_r;
        #1;
        exp_count = 11;  // model: next edge yields 0
        step();
        total_cnt++;
        if (count !== 4'd0 || tc !== 1'b0)
            $display("FAIL illegal_recover: count=%0d tc=%0b required count=0 tc=0", count, tc);
        else pass_cnt++;
        for (int i = 1; i <= 2; i++) begin
            step();
            total_cnt++;
            if (count !== 4'(i) || tc !== 1'b0)
                $display("FAIL illegal_resume_%0d: count=%0d tc=%0b required count=%0d tc=0",
                         i, count, tc, i);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_async_reset_mid();
        test_reset_at_tc();
        test_illegal_state();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
